// File: rtl/calc1_pkg.sv
// Shared types for the calc1 per-port request driver.
// Command/response encodings, request bundle and driver FSM states.
package calc1_pkg;

    localparam int CMD_W  = 4;
    localparam int DATA_W = 32;
    localparam int RESP_W = 2;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } cmd_e;

    typedef enum logic [RESP_W-1:0] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_OVF  = 2'd2,
        RESP_ERR  = 2'd3
    } resp_e;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
    } req_t;

    typedef enum logic [2:0] {
        IDLE,
        SEND1,
        SEND2,
        WAIT,
        HOLD
    } drv_state_e;

    function automatic logic resp_seen(logic [RESP_W-1:0] r);
        return r != RESP_NONE;
    endfunction

endpackage

// File: rtl/calc1_req_fifo.sv
// Synchronous request FIFO for the calc1 port driver.
// Full/empty come from the registered count only.
module calc1_req_fifo
    import calc1_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = req_t
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    T               mem [0:DEPTH-1];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count
                   + {{AW{1'b0}}, do_push}
                   - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/calc1_port_driver.sv
// Per-port calc1 request issuer: buffers requests, drives the
// two-cycle command protocol and returns a result or a timeout.
module calc1_port_driver
    import calc1_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CMD_W-1:0]  req_cmd,
    input  logic [DATA_W-1:0] req_op1,
    input  logic [DATA_W-1:0] req_op2,
    output logic [CMD_W-1:0]  cmd_out,
    output logic [DATA_W-1:0] data_out,
    input  logic [RESP_W-1:0] resp_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RESP_W-1:0] rsp_resp,
    output logic [DATA_W-1:0] rsp_data,
    output logic [CMD_W-1:0]  rsp_cmd,
    output logic              rsp_timeout,
    output logic              err_spurious
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    drv_state_e     state;
    drv_state_e     state_d;
    logic [CW-1:0]  cnt;
    req_t           cur;
    req_t           head;
    req_t           push_data;
    logic           fifo_full;
    logic           fifo_empty;
    logic           pop;
    logic           hit;
    logic           expire;
    logic           finish;

    assign push_data = '{cmd: req_cmd, op1: req_op1, op2: req_op2};
    assign req_ready = !fifo_full;
    assign hit       = resp_seen(resp_in);
    assign expire    = (cnt == CNT_LAST);

    calc1_req_fifo #(
        .DEPTH (DEPTH),
        .T     (req_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req_valid),
        .din   (push_data),
        .pop   (pop),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        pop     = 1'b0;
        finish  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty && !rsp_valid) begin
                    state_d = SEND1;
                    pop     = 1'b1;
                end
            end
            SEND1: state_d = SEND2;
            SEND2: state_d = WAIT;
            WAIT: begin
                if (hit || expire) begin
                    state_d = HOLD;
                    finish  = 1'b1;
                end
            end
            HOLD: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are registered against the next state so each
    // protocol beat lines up with its FSM state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur          <= '0;
            cmd_out      <= '0;
            data_out     <= '0;
            cnt          <= '0;
            rsp_valid    <= 1'b0;
            rsp_resp     <= '0;
            rsp_data     <= '0;
            rsp_cmd      <= '0;
            rsp_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            cmd_out  <= '0;
            data_out <= '0;
            if (pop) begin
                cur      <= head;
                cmd_out  <= head.cmd;
                data_out <= head.op1;
            end
            if (state == SEND1) begin
                data_out <= cur.op2;
            end
            if (state == SEND2) begin
                cnt <= '0;
            end else if (state == WAIT && cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
            if (finish) begin
                rsp_valid   <= 1'b1;
                rsp_cmd     <= cur.cmd;
                rsp_timeout <= !hit;
                rsp_resp    <= hit ? resp_in : RESP_NONE;
                rsp_data    <= hit ? data_in : '0;
            end
            if (state == HOLD && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            // Any response outside WAIT, including one after a timeout.
            if (hit && state != WAIT) begin
                err_spurious <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_calc1_port_driver.sv
// Self-checking bench for calc1_port_driver: directed scenarios plus
// randomized operations against a behavioural calc1 responder model.
module tb_calc1_port_driver;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 32;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cmd;
    logic [31:0] req_op1;
    logic [31:0] req_op2;
    logic [3:0]  cmd_out;
    logic [31:0] data_out;
    logic [1:0]  resp_in;
    logic [31:0] data_in;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_resp;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_cmd;
    logic        rsp_timeout;
    logic        err_spurious;

    int errors = 0;
    int checks = 0;

    op_t         req_q[$];
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
    logic [3:0]  exp_cmd;
    logic        exp_to;
    logic [3:0]  cmd_tab [4];

    always #5 clk = ~clk;

    calc1_port_driver #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_cmd      (req_cmd),
        .req_op1      (req_op1),
        .req_op2      (req_op2),
        .cmd_out      (cmd_out),
        .data_out     (data_out),
        .resp_in      (resp_in),
        .data_in      (data_in),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_resp     (rsp_resp),
        .rsp_data     (rsp_data),
        .rsp_cmd      (rsp_cmd),
        .rsp_timeout  (rsp_timeout),
        .err_spurious (err_spurious)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] calc(logic [3:0] c, logic [31:0] a,
                                         logic [31:0] b);
        case (c)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic offer(input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic exp_rdy);
        op_t o;
        req_valid = 1'b1;
        req_cmd   = c;
        req_op1   = a;
        req_op2   = b;
        chk("req_ready", req_ready, exp_rdy);
        if (exp_rdy) begin
            o.cmd = c;
            o.a   = a;
            o.b   = b;
            req_q.push_back(o);
        end
        tick();
    endtask

    // k >= 0: respond with r on WAIT cycle k; k < 0: never respond.
    task automatic do_op(input int k, input logic [1:0] r);
        op_t         o;
        int          w;
        logic [31:0] d;
        o = req_q.pop_front();
        d = calc(o.cmd, o.a, o.b);
        w = 0;
        while (cmd_out === 4'd0 && w < 300) begin
            tick();
            w++;
        end
        chk("send1_cmd", cmd_out, o.cmd);
        chk("send1_data", data_out, o.a);
        tick();
        chk("send2_cmd", cmd_out, 4'd0);
        chk("send2_data", data_out, o.b);
        tick();
        chk("wait_cmd", cmd_out, 4'd0);
        chk("wait_data", data_out, 32'd0);
        if (k >= 0) begin
            repeat (k) tick();
            chk("wait_quiet", rsp_valid, 1'b0);
            resp_in = r;
            data_in = d;
            tick();
            resp_in = 2'd0;
            data_in = 32'd0;
            exp_resp = r;
            exp_data = d;
            exp_to   = 1'b0;
        end else begin
            repeat (TIMEOUT - 1) tick();
            chk("wait_quiet", rsp_valid, 1'b0);
            tick();
            exp_resp = 2'd0;
            exp_data = 32'd0;
            exp_to   = 1'b1;
        end
        exp_cmd = o.cmd;
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_resp", rsp_resp, exp_resp);
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_cmd", rsp_cmd, exp_cmd);
        chk("rsp_timeout", rsp_timeout, exp_to);
    endtask

    task automatic take_rsp(input int delay);
        repeat (delay) begin
            chk("hold_valid", rsp_valid, 1'b1);
            chk("hold_data", rsp_data, exp_data);
            tick();
        end
        chk("take_valid", rsp_valid, 1'b1);
        chk("take_resp", rsp_resp, exp_resp);
        chk("take_data", rsp_data, exp_data);
        chk("take_cmd", rsp_cmd, exp_cmd);
        chk("take_timeout", rsp_timeout, exp_to);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_drop", rsp_valid, 1'b0);
    endtask

    initial begin
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        int          k;

        cmd_tab[0] = 4'd1;
        cmd_tab[1] = 4'd2;
        cmd_tab[2] = 4'd5;
        cmd_tab[3] = 4'd6;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_cmd   = '0;
        req_op1   = '0;
        req_op2   = '0;
        resp_in   = '0;
        data_in   = '0;
        rsp_ready = 1'b0;
        repeat (2) tick();
        chk("rst_cmd", cmd_out, 4'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_timeout", rsp_timeout, 1'b0);
        chk("rst_spurious", err_spurious, 1'b0);
        chk("rst_ready", req_ready, 1'b1);
        reset = 1'b1;
        tick();

        // Reset while WAIT with a second request still buffered.
        offer(4'd1, 32'h11, 32'h22, 1'b1);
        offer(4'd2, 32'h33, 32'h44, 1'b1);
        req_valid = 1'b0;
        chk("lat_cmd", cmd_out, 4'd1);
        repeat (4) tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_cmd", cmd_out, 4'd0);
        chk("mid_rst_valid", rsp_valid, 1'b0);
        chk("mid_rst_ready", req_ready, 1'b1);
        req_q.delete();
        tick();
        reset = 1'b1;
        repeat (6) begin
            tick();
            chk("post_rst_idle", cmd_out, 4'd0);
        end

        // ADD 5+3, response two cycles into WAIT.
        offer(4'd1, 32'h5, 32'h3, 1'b1);
        req_valid = 1'b0;
        do_op(2, 2'd1);
        chk("add_data", rsp_data, 32'h8);
        take_rsp(2);

        // Response on the exact expiry cycle wins.
        offer(4'd2, 32'd10, 32'd3, 1'b1);
        req_valid = 1'b0;
        do_op(TIMEOUT - 1, 2'd2);
        take_rsp(0);

        // SHR all-ones by 4.
        offer(4'd6, 32'hFFFF_FFFF, 32'h4, 1'b1);
        req_valid = 1'b0;
        do_op(5, 2'd1);
        take_rsp(1);

        // FIFO fill while the FSM is parked in HOLD.
        offer(4'd5, 32'h1, 32'h3, 1'b1);
        req_valid = 1'b0;
        do_op(1, 2'd1);
        for (int i = 0; i < 5; i++) begin
            offer(4'd1, 32'h100 + i, 32'h10 * i,
                  req_q.size() < DEPTH);
        end
        req_valid = 1'b0;
        chk("fifo_full", req_ready, 1'b0);
        take_rsp(3);
        for (int i = 0; i < DEPTH; i++) begin
            do_op(i, 2'd1);
            take_rsp(0);
        end
        repeat (4) begin
            tick();
            chk("drain_idle", cmd_out, 4'd0);
        end
        chk("drain_ready", req_ready, 1'b1);

        // Randomized operations.
        for (int n = 0; n < 10; n++) begin
            c = cmd_tab[$urandom_range(0, 3)];
            a = $urandom;
            b = $urandom;
            k = ($urandom_range(0, 3) == 0) ? -1
              : int'($urandom_range(0, TIMEOUT - 1));
            offer(c, a, b, 1'b1);
            req_valid = 1'b0;
            do_op(k, 2'($urandom_range(1, 3)));
            take_rsp(int'($urandom_range(0, 3)));
        end
        chk("rand_no_spurious", err_spurious, 1'b0);

        // Timeout, then a late response.
        offer(4'd1, 32'h7, 32'h9, 1'b1);
        req_valid = 1'b0;
        do_op(-1, 2'd0);
        chk("pre_late_spur", err_spurious, 1'b0);
        resp_in = 2'd1;
        data_in = 32'h1234;
        tick();
        resp_in = 2'd0;
        data_in = 32'd0;
        chk("late_spur", err_spurious, 1'b1);
        take_rsp(0);
        repeat (3) begin
            tick();
            chk("late_dropped", rsp_valid, 1'b0);
        end
        chk("spur_sticky", err_spurious, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
